// File: rtl/wb_biu_port_if.sv
// wb_biu_port_if
// Wishbone B4 bus bundle between a bus-interface unit and a Wishbone slave.
// Suffixes are from the master's point of view.
//   wb_cyc_o   master -> slave   bus cycle in progress
//   wb_stb_o   master -> slave   strobe / transfer request
//   wb_we_o    master -> slave   write enable
//   wb_sel_o   master -> slave   byte selects (DATA_W/8 bits)
//   wb_adr_o   master -> slave   address (ADDR_W bits)
//   wb_dat_o   master -> slave   write data (DATA_W bits)
//   wb_dat_i   slave  -> master  read data (DATA_W bits)
//   wb_ack_i   slave  -> master  normal termination
//   wb_err_i   slave  -> master  error termination
//   wb_stall_i slave  -> master  pipelined-mode stall
interface wb_biu_port_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int SEL_W = DATA_W / 8;

   logic              wb_cyc_o;
   logic              wb_stb_o;
   logic              wb_we_o;
   logic [SEL_W-1:0]  wb_sel_o;
   logic [ADDR_W-1:0] wb_adr_o;
   logic [DATA_W-1:0] wb_dat_o;
   logic [DATA_W-1:0] wb_dat_i;
   logic              wb_ack_i;
   logic              wb_err_i;
   logic              wb_stall_i;

   modport master (
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
      input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
   );

   modport slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
      output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
   );
endinterface

// File: rtl/wb_biu_port.sv
// wb_biu_port
// Wishbone B4 bus-interface unit for one RISC-V core memory port. Core
// requests are buffered in a DEPTH-entry command FIFO and issued either as
// pipelined Wishbone transfers (up to MAX_OUT outstanding) or as classic
// single transfers. Responses come back in order carrying the request tag.
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   req_rd_i          read request
//   req_wr_i          write byte enables (nonzero = write, wins over read)
//   req_addr_i        request address
//   req_data_i        write data
//   req_tag_i         request tag
//   req_accept_o      command FIFO can take a request this cycle
//   resp_valid_o      one-cycle response strobe
//   resp_data_o       read data (0 for writes and errors)
//   resp_tag_o        tag of the completing transfer
//   resp_error_o      transfer terminated by wb_err_i
//   busy_o            queued or in-flight work exists
//   wb                Wishbone master side of wb_biu_port_if
module wb_biu_port #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TAG_W     = 11,
   parameter int DEPTH     = 4,
   parameter int MAX_OUT   = 2,
   parameter int PIPELINED = 1,
   localparam int SEL_W    = DATA_W / 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_rd_i,
   input  logic [SEL_W-1:0]  req_wr_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_data_i,
   input  logic [TAG_W-1:0]  req_tag_i,
   output logic              req_accept_o,
   output logic              resp_valid_o,
   output logic [DATA_W-1:0] resp_data_o,
   output logic [TAG_W-1:0]  resp_tag_o,
   output logic              resp_error_o,
   output logic              busy_o,
   wb_biu_port_if.master     wb
);
   localparam int AW  = $clog2(DEPTH);
   localparam int OW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int OCW = $clog2(MAX_OUT + 1);
   localparam logic [OCW-1:0] MAX_OUT_C = OCW'(MAX_OUT);
   localparam logic [AW:0]    DEPTH_C   = (AW+1)'(DEPTH);

   typedef struct packed {
      logic              we;
      logic [SEL_W-1:0]  sel;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
   } entry_t;

   typedef enum logic {ST_IDLE, ST_REQ} state_t;

   entry_t           mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_next;
   logic [AW:0]      count, count_after_pop, count_next;
   entry_t           cur_q, push_entry, head_next;
   logic             stb_q, cyc_q, stb_d, cyc_d;
   logic [TAG_W:0]   tmem [MAX_OUT];
   logic [OW-1:0]    twr, trd;
   logic [OCW-1:0]   out_q, out_next;
   logic [TAG_W:0]   resp_meta;
   state_t           state_q, state_d;
   logic             wr_any, push, pop, accept, bus_term, resp_valid, tpop;

   function automatic logic [OW-1:0] tag_ptr_next(input logic [OW-1:0] p);
      return (p == OW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
   endfunction

   // Request side: a write wins over a simultaneous read, reads select all bytes.
   always_comb begin
      wr_any          = |req_wr_i;
      push            = (req_rd_i | wr_any) & req_accept_o;
      push_entry      = '0;
      push_entry.we   = wr_any;
      push_entry.sel  = wr_any ? req_wr_i : '1;
      push_entry.addr = req_addr_i;
      push_entry.data = req_data_i;
      push_entry.tag  = req_tag_i;
   end

   // Bus events. A response needs a transfer in flight: something outstanding
   // or a strobe accepted in this very cycle (zero-latency slave). Classic
   // mode only ever has the presented transfer, so cyc alone qualifies it.
   always_comb begin
      bus_term = wb.wb_ack_i | wb.wb_err_i;
      if (PIPELINED != 0) begin
         accept     = stb_q & ~wb.wb_stall_i;
         resp_valid = cyc_q & bus_term & ((out_q != '0) | accept);
         pop        = accept;
      end else begin
         accept     = 1'b0;
         resp_valid = cyc_q & bus_term;
         pop        = (state_q == ST_REQ) & bus_term;
      end
      tpop = (PIPELINED != 0) & resp_valid;
      // With nothing outstanding the completing transfer is the one on the bus now.
      if ((PIPELINED != 0) && (out_q != '0)) resp_meta = tmem[trd];
      else                                   resp_meta = {cur_q.we, cur_q.tag};
   end

   // Next FIFO occupancy and the entry to present after this edge. When the
   // FIFO drains to nothing the incoming request bypasses straight to the bus
   // registers so a strobe can appear the cycle after the push.
   always_comb begin
      count_after_pop = count - (AW+1)'(pop);
      count_next      = count_after_pop + (AW+1)'(push);
      rd_ptr_next     = rd_ptr + AW'(pop);
      head_next       = (count_after_pop == '0) ? push_entry : mem[rd_ptr_next];
      out_next        = out_q + OCW'(accept) - OCW'(tpop);
   end

   // Next-state and next bus-control logic. Pipelined mode keeps strobing
   // while work is queued and the outstanding window has room; classic mode
   // runs IDLE->REQ->IDLE so cyc/stb drop for one cycle between transfers.
   always_comb begin
      state_d = state_q;
      stb_d   = 1'b0;
      cyc_d   = 1'b0;
      if (PIPELINED != 0) begin
         stb_d = (count_next != '0) && (out_next < MAX_OUT_C);
         cyc_d = stb_d || (out_next != '0);
      end else begin
         case (state_q)
            ST_IDLE: if (count_next != '0) state_d = ST_REQ;
            ST_REQ:  if (bus_term)         state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
         endcase
         stb_d = (state_d == ST_REQ);
         cyc_d = stb_d;
      end
   end

   // Classic-mode state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Storage arrays carry no reset; only pointers and counts define validity.
   always_ff @(posedge clk_i) begin
      if (push)   mem[wr_ptr] <= push_entry;
      if (accept) tmem[twr]   <= {cur_q.we, cur_q.tag};
   end

   // Pointers, counts and the registered bus outputs. The bus payload is
   // zeroed whenever no strobe is presented.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         cur_q  <= '0;
         stb_q  <= 1'b0;
         cyc_q  <= 1'b0;
         twr    <= '0;
         trd    <= '0;
         out_q  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= rd_ptr_next;
         count  <= count_next;
         cur_q  <= stb_d ? head_next : '0;
         stb_q  <= stb_d;
         cyc_q  <= cyc_d;
         if (accept) twr <= tag_ptr_next(twr);
         if (tpop)   trd <= tag_ptr_next(trd);
         out_q  <= out_next;
      end
   end

   assign wb.wb_cyc_o    = cyc_q;
   assign wb.wb_stb_o    = stb_q;
   assign wb.wb_we_o     = cur_q.we;
   assign wb.wb_sel_o    = cur_q.sel;
   assign wb.wb_adr_o    = cur_q.addr;
   assign wb.wb_dat_o    = cur_q.data;

   assign req_accept_o   = (count != DEPTH_C);
   assign resp_valid_o   = resp_valid;
   assign resp_error_o   = resp_valid & wb.wb_err_i;
   assign resp_tag_o     = resp_valid ? resp_meta[TAG_W-1:0] : '0;
   assign resp_data_o    = (resp_valid & ~resp_meta[TAG_W] & ~wb.wb_err_i) ? wb.wb_dat_i : '0;
   assign busy_o         = (count != '0) | (out_q != '0) | stb_q;
endmodule

// File: tb/tb_wb_biu_port.sv
// tb_wb_biu_port
// Directed bench for wb_biu_port. One classic and one pipelined instance
// share the core-side request inputs; whichever is not under test is held
// in reset. Inputs change on the falling edge, outputs are compared 1 ns later.
module tb_wb_biu_port;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int TAG_W  = 11;
   localparam int SEL_W  = DATA_W / 8;

   logic              clk = 1'b0;
   logic              rst_c, rst_p;
   logic              req_rd;
   logic [SEL_W-1:0]  req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic [TAG_W-1:0]  req_tag;

   logic              c_accept, c_resp_valid, c_resp_error, c_busy;
   logic [DATA_W-1:0] c_resp_data;
   logic [TAG_W-1:0]  c_resp_tag;
   logic              p_accept, p_resp_valid, p_resp_error, p_busy;
   logic [DATA_W-1:0] p_resp_data;
   logic [TAG_W-1:0]  p_resp_tag;

   int checks   = 0;
   int failures = 0;

   wb_biu_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wb_c ();
   wb_biu_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wb_p ();

   always #5 clk = ~clk;

   wb_biu_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(4),
                 .MAX_OUT(2), .PIPELINED(0)) dut_c (
      .clk_i(clk), .rst_i(rst_c),
      .req_rd_i(req_rd), .req_wr_i(req_wr), .req_addr_i(req_addr),
      .req_data_i(req_data), .req_tag_i(req_tag), .req_accept_o(c_accept),
      .resp_valid_o(c_resp_valid), .resp_data_o(c_resp_data),
      .resp_tag_o(c_resp_tag), .resp_error_o(c_resp_error), .busy_o(c_busy),
      .wb(wb_c)
   );

   wb_biu_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(4),
                 .MAX_OUT(2), .PIPELINED(1)) dut_p (
      .clk_i(clk), .rst_i(rst_p),
      .req_rd_i(req_rd), .req_wr_i(req_wr), .req_addr_i(req_addr),
      .req_data_i(req_data), .req_tag_i(req_tag), .req_accept_o(p_accept),
      .resp_valid_o(p_resp_valid), .resp_data_o(p_resp_data),
      .resp_tag_o(p_resp_tag), .resp_error_o(p_resp_error), .busy_o(p_busy),
      .wb(wb_p)
   );

   // Drive the shared core-side request inputs for one cycle.
   task automatic applyStimulus(input logic rd, input logic [SEL_W-1:0] wr,
                                input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] data,
                                input logic [TAG_W-1:0] tag);
      req_rd   = rd;
      req_wr   = wr;
      req_addr = addr;
      req_data = data;
      req_tag  = tag;
   endtask

   task automatic idleRequest();
      applyStimulus(1'b0, '0, '0, '0, '0);
   endtask

   // Slave-side responses for the classic instance.
   task automatic driveSlaveC(input logic ack, input logic err, input logic [DATA_W-1:0] dat);
      wb_c.wb_ack_i   = ack;
      wb_c.wb_err_i   = err;
      wb_c.wb_stall_i = 1'b0;
      wb_c.wb_dat_i   = dat;
   endtask

   // Slave-side responses for the pipelined instance.
   task automatic driveSlaveP(input logic ack, input logic err, input logic stall,
                              input logic [DATA_W-1:0] dat);
      wb_p.wb_ack_i   = ack;
      wb_p.wb_err_i   = err;
      wb_p.wb_stall_i = stall;
      wb_p.wb_dat_i   = dat;
   endtask

   // One comparison: count it, and on mismatch count and report it.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      rst_c = 1'b1;
      rst_p = 1'b1;
      idleRequest();
      driveSlaveC(1'b0, 1'b0, '0);
      driveSlaveP(1'b0, 1'b0, 1'b0, '0);
      repeat (3) @(negedge clk);
      #1;
      $display("[TB] reset state");
      checkOutput("rst_c_cyc", wb_c.wb_cyc_o, 0);
      checkOutput("rst_c_stb", wb_c.wb_stb_o, 0);
      checkOutput("rst_c_accept", c_accept, 1);
      checkOutput("rst_c_busy", c_busy, 0);
      checkOutput("rst_p_cyc", wb_p.wb_cyc_o, 0);
      checkOutput("rst_p_adr", wb_p.wb_adr_o, 0);
      checkOutput("rst_p_accept", p_accept, 1);
      checkOutput("rst_p_rvalid", p_resp_valid, 0);

      // ---- classic read, ack in the second strobe cycle ----
      $display("[TB] classic read");
      @(negedge clk); rst_c = 1'b0;
      @(negedge clk); applyStimulus(1'b1, 4'b0000, 32'h100, '0, 11'd5); #1;
      checkOutput("c1_stb_pre", wb_c.wb_stb_o, 0);
      @(negedge clk); idleRequest(); #1;
      checkOutput("c1_stb", wb_c.wb_stb_o, 1);
      checkOutput("c1_cyc", wb_c.wb_cyc_o, 1);
      checkOutput("c1_adr", wb_c.wb_adr_o, 32'h100);
      checkOutput("c1_we", wb_c.wb_we_o, 0);
      checkOutput("c1_sel", wb_c.wb_sel_o, 4'hF);
      checkOutput("c1_rvalid_wait", c_resp_valid, 0);
      checkOutput("c1_busy", c_busy, 1);
      @(negedge clk); driveSlaveC(1'b1, 1'b0, 32'hDEADBEEF); #1;
      checkOutput("c1_rvalid", c_resp_valid, 1);
      checkOutput("c1_rdata", c_resp_data, 32'hDEADBEEF);
      checkOutput("c1_rtag", c_resp_tag, 5);
      checkOutput("c1_rerr", c_resp_error, 0);
      @(negedge clk); driveSlaveC(1'b0, 1'b0, '0); #1;
      checkOutput("c1_cyc_drop", wb_c.wb_cyc_o, 0);
      checkOutput("c1_adr_idle", wb_c.wb_adr_o, 0);
      checkOutput("c1_busy_end", c_busy, 0);

      // ---- classic write terminated by error ----
      $display("[TB] classic write with error");
      @(negedge clk); applyStimulus(1'b0, 4'b0011, 32'h204, 32'h12345678, 11'd9); #1;
      checkOutput("c5_stb_pre", wb_c.wb_stb_o, 0);
      @(negedge clk); idleRequest(); driveSlaveC(1'b0, 1'b1, 32'hFFFFFFFF); #1;
      checkOutput("c5_we", wb_c.wb_we_o, 1);
      checkOutput("c5_sel", wb_c.wb_sel_o, 4'b0011);
      checkOutput("c5_adr", wb_c.wb_adr_o, 32'h204);
      checkOutput("c5_dat", wb_c.wb_dat_o, 32'h12345678);
      checkOutput("c5_rvalid", c_resp_valid, 1);
      checkOutput("c5_rerr", c_resp_error, 1);
      checkOutput("c5_rdata", c_resp_data, 0);
      checkOutput("c5_rtag", c_resp_tag, 9);
      @(negedge clk); driveSlaveC(1'b0, 1'b0, '0); #1;
      checkOutput("c5_cyc_drop", wb_c.wb_cyc_o, 0);
      checkOutput("c5_busy_end", c_busy, 0);

      // ---- pipelined: four back-to-back reads, ack one cycle after accept ----
      @(negedge clk); rst_c = 1'b1; rst_p = 1'b0;
      $display("[TB] pipelined back-to-back reads");
      for (int i = 0; i <= 6; i++) begin
         @(negedge clk);
         if (i <= 3) applyStimulus(1'b1, '0, 32'h10 + 32'(4 * i), '0, 11'(i + 1));
         else        idleRequest();
         driveSlaveP((i >= 2) && (i <= 5), 1'b0, 1'b0, 32'hA0 + 32'(i - 1));
         #1;
         checkOutput("p2_stb", wb_p.wb_stb_o, (i >= 1) && (i <= 4));
         checkOutput("p2_cyc", wb_p.wb_cyc_o, (i >= 1) && (i <= 5));
         if ((i >= 1) && (i <= 4)) checkOutput("p2_adr", wb_p.wb_adr_o, 32'h10 + 32'(4 * (i - 1)));
         checkOutput("p2_rvalid", p_resp_valid, (i >= 2) && (i <= 5));
         if ((i >= 2) && (i <= 5)) begin
            checkOutput("p2_rtag", p_resp_tag, 11'(i - 1));
            checkOutput("p2_rdata", p_resp_data, 32'hA0 + 32'(i - 1));
         end
      end
      checkOutput("p2_busy_end", p_busy, 0);

      // ---- pipelined: outstanding window of two with acks withheld ----
      $display("[TB] pipelined outstanding limit");
      @(negedge clk); applyStimulus(1'b1, '0, 32'h300, '0, 11'd7); driveSlaveP(1'b0, 1'b0, 1'b0, '0); #1;
      checkOutput("p3_stb0", wb_p.wb_stb_o, 0);
      @(negedge clk); applyStimulus(1'b1, '0, 32'h304, '0, 11'd8); #1;
      checkOutput("p3_stb1", wb_p.wb_stb_o, 1);
      checkOutput("p3_adr1", wb_p.wb_adr_o, 32'h300);
      @(negedge clk); applyStimulus(1'b1, '0, 32'h308, '0, 11'd9); #1;
      checkOutput("p3_stb2", wb_p.wb_stb_o, 1);
      checkOutput("p3_adr2", wb_p.wb_adr_o, 32'h304);
      @(negedge clk); idleRequest(); #1;
      checkOutput("p3_stb_full", wb_p.wb_stb_o, 0);
      checkOutput("p3_cyc_full", wb_p.wb_cyc_o, 1);
      @(negedge clk); #1;
      checkOutput("p3_stb_full2", wb_p.wb_stb_o, 0);
      @(negedge clk); driveSlaveP(1'b1, 1'b0, 1'b0, 32'hB7); #1;
      checkOutput("p3_stb_ack", wb_p.wb_stb_o, 0);
      checkOutput("p3_rvalid7", p_resp_valid, 1);
      checkOutput("p3_rtag7", p_resp_tag, 7);
      @(negedge clk); driveSlaveP(1'b0, 1'b0, 1'b0, '0); #1;
      checkOutput("p3_stb3", wb_p.wb_stb_o, 1);
      checkOutput("p3_adr3", wb_p.wb_adr_o, 32'h308);
      checkOutput("p3_rvalid_none", p_resp_valid, 0);
      @(negedge clk); driveSlaveP(1'b1, 1'b0, 1'b0, 32'hB8); #1;
      checkOutput("p3_rtag8", p_resp_tag, 8);
      checkOutput("p3_rdata8", p_resp_data, 32'hB8);
      checkOutput("p3_stb_done", wb_p.wb_stb_o, 0);
      @(negedge clk); driveSlaveP(1'b1, 1'b0, 1'b0, 32'hB9); #1;
      checkOutput("p3_rtag9", p_resp_tag, 9);
      @(negedge clk); driveSlaveP(1'b0, 1'b0, 1'b0, '0); #1;
      checkOutput("p3_cyc_end", wb_p.wb_cyc_o, 0);
      checkOutput("p3_busy_end", p_busy, 0);

      // ---- pipelined: fill the FIFO with writes while stalled ----
      $display("[TB] pipelined FIFO fill under stall");
      driveSlaveP(1'b0, 1'b0, 1'b1, '0);
      @(negedge clk); applyStimulus(1'b1, 4'b1111, 32'h400, 32'h11111111, 11'd20); #1;
      checkOutput("p4_accept0", p_accept, 1);
      @(negedge clk); applyStimulus(1'b0, 4'b0001, 32'h404, 32'h22222222, 11'd21); #1;
      checkOutput("p4_accept1", p_accept, 1);
      checkOutput("p4_stb_stalled", wb_p.wb_stb_o, 1);
      @(negedge clk); applyStimulus(1'b0, 4'b0110, 32'h408, 32'h33333333, 11'd22); #1;
      checkOutput("p4_accept2", p_accept, 1);
      @(negedge clk); applyStimulus(1'b0, 4'b1000, 32'h40C, 32'h44444444, 11'd23); #1;
      checkOutput("p4_accept3", p_accept, 1);
      @(negedge clk); applyStimulus(1'b0, 4'b1111, 32'h410, 32'h55555555, 11'd24); #1;
      checkOutput("p4_accept_full", p_accept, 0);
      @(negedge clk); idleRequest(); driveSlaveP(1'b0, 1'b0, 1'b0, '0); #1;
      checkOutput("p4_accept_full2", p_accept, 0);
      checkOutput("p4_adr0", wb_p.wb_adr_o, 32'h400);
      checkOutput("p4_we0", wb_p.wb_we_o, 1);
      checkOutput("p4_sel0", wb_p.wb_sel_o, 4'hF);
      checkOutput("p4_dat0", wb_p.wb_dat_o, 32'h11111111);
      @(negedge clk); driveSlaveP(1'b1, 1'b0, 1'b0, 32'hCAFEF00D); #1;
      checkOutput("p4_accept_free", p_accept, 1);
      checkOutput("p4_adr1", wb_p.wb_adr_o, 32'h404);
      checkOutput("p4_sel1", wb_p.wb_sel_o, 4'b0001);
      checkOutput("p4_dat1", wb_p.wb_dat_o, 32'h22222222);
      checkOutput("p4_rtag20", p_resp_tag, 20);
      checkOutput("p4_rdata_wr", p_resp_data, 0);
      checkOutput("p4_rerr", p_resp_error, 0);
      @(negedge clk); #1;
      checkOutput("p4_adr2", wb_p.wb_adr_o, 32'h408);
      checkOutput("p4_sel2", wb_p.wb_sel_o, 4'b0110);
      checkOutput("p4_rtag21", p_resp_tag, 21);
      @(negedge clk); #1;
      checkOutput("p4_adr3", wb_p.wb_adr_o, 32'h40C);
      checkOutput("p4_sel3", wb_p.wb_sel_o, 4'b1000);
      checkOutput("p4_dat3", wb_p.wb_dat_o, 32'h44444444);
      checkOutput("p4_rtag22", p_resp_tag, 22);
      @(negedge clk); #1;
      checkOutput("p4_stb_dropped", wb_p.wb_stb_o, 0);
      checkOutput("p4_rtag23", p_resp_tag, 23);
      checkOutput("p4_cyc_tail", wb_p.wb_cyc_o, 1);
      @(negedge clk); driveSlaveP(1'b0, 1'b0, 1'b0, '0); #1;
      checkOutput("p4_cyc_end", wb_p.wb_cyc_o, 0);
      checkOutput("p4_busy_end", p_busy, 0);

      // ---- pipelined: reset with two outstanding and two queued ----
      $display("[TB] pipelined mid-transfer reset");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); applyStimulus(1'b1, '0, 32'h600 + 32'(4 * i), '0, 11'(30 + i));
      end
      @(negedge clk); idleRequest(); #1;
      checkOutput("p6_busy_pre", p_busy, 1);
      checkOutput("p6_cyc_pre", wb_p.wb_cyc_o, 1);
      checkOutput("p6_stb_pre", wb_p.wb_stb_o, 0);
      rst_p = 1'b1;
      @(negedge clk); rst_p = 1'b0; driveSlaveP(1'b1, 1'b0, 1'b0, 32'h77); #1;
      checkOutput("p6_cyc_rst", wb_p.wb_cyc_o, 0);
      checkOutput("p6_stb_rst", wb_p.wb_stb_o, 0);
      checkOutput("p6_busy_rst", p_busy, 0);
      checkOutput("p6_accept_rst", p_accept, 1);
      checkOutput("p6_rvalid_stale", p_resp_valid, 0);
      @(negedge clk); driveSlaveP(1'b0, 1'b0, 1'b0, '0); #1;
      checkOutput("p6_stb_after", wb_p.wb_stb_o, 0);
      checkOutput("p6_busy_after", p_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end
endmodule
